reg_j_digit_tx: RTL and testbench

- Reads a 12-bit register value and emits it as four 3-bit octal digits, one per handshake, on the 3-bit digit bus.
- It is the read-out counterpart of the digit-wise J register load, where one octal digit is inserted per load function. A consumer can rebuild the word by writing digit k into field k.
- Sits between a 12-bit register (J or a peer) and any 3-bit-wide sink: stack, output port, or digit-load path.

---
 rtl/reg_j_digit_tx.sv | 100 ++++++++++
 tb/tb_reg_j_digit_tx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_j_digit_tx.sv
// Octal digit serialiser: captures a WIDTH-bit word and emits it one 3-bit field
// per valid/ready handshake, MSB-first or LSB-first, with zero-bubble back-to-back loads.
module reg_j_digit_tx #(
    parameter int WIDTH     = 12,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [WIDTH-1:0]              load_word,
    input  logic                          flush,
    output logic                          dig_valid,
    input  logic                          dig_ready,
    output logic [2:0]                    dig_data,
    output logic [$clog2(WIDTH/3)-1:0]    dig_idx,
    output logic                          dig_last,
    output logic                          busy
);

    localparam int N  = WIDTH / 3;
    localparam int IW = $clog2(N);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            last_q, last_d;
    logic [IW-1:0]   cnt_inc;
    logic            xfer;
    logic            accept;

    assign dig_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign dig_idx    = idx_q;
    assign dig_last   = last_q;
    // The current digit always sits at the end of the shift register that leaves first.
    assign dig_data   = MSB_FIRST ? shreg_q[WIDTH-1 -: 3] : shreg_q[2:0];

    assign xfer       = dig_valid && dig_ready;
    assign load_ready = (state_q == IDLE) || (xfer && last_q && !flush);
    assign accept     = load_valid && load_ready;
    assign cnt_inc    = cnt_q + IW'(1);

    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        if (flush && (state_q == SEND)) begin
            state_d = IDLE;
            shreg_d = '0;
            cnt_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
        end else if (accept) begin
            state_d = SEND;
            shreg_d = load_word;
            cnt_d   = '0;
            idx_d   = MSB_FIRST ? IW'(N - 1) : {IW{1'b0}};
            last_d  = (N == 1);
        end else if (xfer) begin
            if (last_q) begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
                idx_d   = '0;
                last_d  = 1'b0;
            end else begin
                shreg_d = MSB_FIRST ? {shreg_q[WIDTH-4:0], 3'b000}
                                    : {3'b000, shreg_q[WIDTH-1:3]};
                cnt_d   = cnt_inc;
                idx_d   = MSB_FIRST ? idx_q - IW'(1) : idx_q + IW'(1);
                last_d  = (cnt_inc == IW'(N - 1));
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_reg_j_digit_tx.sv
// Bench for reg_j_digit_tx: two instances (LSB-first, MSB-first) share stimulus and are
// compared every cycle against a queue-of-digits reference model, plus directed scenarios.
module tb_reg_j_digit_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [11:0] load_word = '0;
    logic        flush = 1'b0;
    logic        dig_ready = 1'b0;

    // index 0: MSB_FIRST = 0, index 1: MSB_FIRST = 1
    logic [1:0]  lr, dv, dl, bz;
    logic [2:0]  dd [2];
    logic [1:0]  di [2];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0] data;
        logic [1:0] idx;
        logic       last;
    } dig_t;

    dig_t mq [2][$];

    always #5 clk = ~clk;

    reg_j_digit_tx #(.WIDTH(12), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[0]),
        .load_word(load_word), .flush(flush), .dig_valid(dv[0]), .dig_ready(dig_ready),
        .dig_data(dd[0]), .dig_idx(di[0]), .dig_last(dl[0]), .busy(bz[0])
    );

    reg_j_digit_tx #(.WIDTH(12), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(lr[1]),
        .load_word(load_word), .flush(flush), .dig_valid(dv[1]), .dig_ready(dig_ready),
        .dig_data(dd[1]), .dig_idx(di[1]), .dig_last(dl[1]), .busy(bz[1])
    );

    // Splits a word into its four octal digits in emission order.
    task automatic push_word(input int m, input logic [11:0] w);
        dig_t d;
        for (int k = 0; k < 4; k++) begin
            int f;
            f = (m == 1) ? 3 - k : k;
            d.data = w[3*f +: 3];
            d.idx  = f[1:0];
            d.last = (k == 3);
            mq[m].push_back(d);
        end
    endtask

    // One clock: drive at the falling edge, compare both instances with the model, advance the model.
    task automatic cycle(input logic rst, input logic lv, input logic [11:0] w,
                         input logic rdy, input logic fl);
        @(negedge clk);
        rst_n = rst; load_valid = lv; load_word = w; dig_ready = rdy; flush = fl;
        #1;
        for (int m = 0; m < 2; m++) begin
            logic       ev, elr;
            logic [8:0] e_vec, o_vec;
            dig_t       h;
            ev  = (mq[m].size() > 0);
            elr = !ev || (mq[m].size() == 1 && rdy && !fl);
            h   = '{data: 3'd0, idx: 2'd0, last: 1'b0};
            if (ev) h = mq[m][0];
            if (rst) begin
                e_vec = {ev, ev, elr, h.data, h.idx, h.last};
                o_vec = {dv[m], bz[m], lr[m], dv[m] ? dd[m] : 3'd0,
                         dv[m] ? di[m] : 2'd0, dv[m] ? dl[m] : 1'b0};
                n_checks++;
                if (o_vec !== e_vec)
                    $display("FAIL model_cmp inst%0d t=%0t: {valid,busy,lready,data,idx,last} got %b want %b",
                             m, $time, o_vec, e_vec);
                else
                    n_pass++;
                if (ev && fl) begin
                    mq[m].delete();
                end else begin
                    if (ev && rdy) void'(mq[m].pop_front());
                    if (lv && elr) push_word(m, w);
                end
            end else begin
                mq[m].delete();
            end
        end
    endtask

    task automatic test_reset;
        cycle(1'b0, 1'b1, 12'o7777, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 12'o0000, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 12'o0000, 1'b0, 1'b0);
        for (int m = 0; m < 2; m++) begin
            n_checks++;
            if ({dv[m], bz[m], lr[m], dd[m], di[m], dl[m]} !== 9'b001_000_00_0)
                $display("FAIL reset_state inst%0d: got %b want 001000000",
                         m, {dv[m], bz[m], lr[m], dd[m], di[m], dl[m]});
            else
                n_pass++;
        end
    endtask

    task automatic test_msb_order;
        logic [2:0] exp_d [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [1:0] exp_i [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
        cycle(1'b1, 1'b1, 12'o1234, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
            n_checks++;
            if ({dv[1], dd[1], di[1], dl[1]} !== {1'b1, exp_d[k], exp_i[k], k == 3})
                $display("FAIL msb_digit%0d: {valid,data,idx,last} got %b want %b",
                         k, {dv[1], dd[1], di[1], dl[1]}, {1'b1, exp_d[k], exp_i[k], k == 3});
            else
                n_pass++;
        end
        cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
        n_checks++;
        if (bz[1] !== 1'b0) $display("FAIL msb_done_busy: got %b want 0", bz[1]);
        else n_pass++;
    endtask

    task automatic test_lsb_order;
        logic [2:0]  exp_d [4] = '{3'd1, 3'd5, 3'd0, 3'd7};
        logic [11:0] rebuilt = '0;
        cycle(1'b1, 1'b1, 12'o7051, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
            rebuilt[3*di[0] +: 3] = dd[0];
            n_checks++;
            if ({dd[0], di[0]} !== {exp_d[k], 2'(k)})
                $display("FAIL lsb_digit%0d: {data,idx} got %b want %b",
                         k, {dd[0], di[0]}, {exp_d[k], 2'(k)});
            else
                n_pass++;
        end
        n_checks++;
        if (rebuilt !== 12'o7051) $display("FAIL lsb_rebuild: got %o want 7051", rebuilt);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        logic       rdy_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0] exp_d [4]   = '{3'd4, 3'd3, 3'd2, 3'd1};
        logic [2:0] got [$];
        cycle(1'b1, 1'b1, 12'o4321, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            cycle(1'b1, 1'b0, 12'o7777, rdy_pat[k], 1'b0);
            if (dv[1] && rdy_pat[k]) got.push_back(dd[1]);
        end
        n_checks++;
        if (got.size() != 4) $display("FAIL bp_count: got %0d digits want 4", got.size());
        else n_pass++;
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_d[k]) $display("FAIL bp_digit%0d: got %0d want %0d", k, got[k], exp_d[k]);
            else n_pass++;
        end
        cycle(1'b1, 1'b0, 12'o7777, 1'b1, 1'b0);
        n_checks++;
        if (bz[1] !== 1'b0) $display("FAIL bp_done_busy: got %b want 0", bz[1]);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_d [8]  = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0};
        logic       exp_lr [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        cycle(1'b1, 1'b1, 12'o0007, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, k < 4, 12'o7000, 1'b1, 1'b0);
            n_checks++;
            if ({dv[1], dd[1], lr[1]} !== {1'b1, exp_d[k], exp_lr[k]})
                $display("FAIL b2b_cycle%0d: {valid,data,lready} got %b want %b",
                         k, {dv[1], dd[1], lr[1]}, {1'b1, exp_d[k], exp_lr[k]});
            else
                n_pass++;
        end
    endtask

    task automatic test_flush;
        logic [2:0] exp_d [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        cycle(1'b1, 1'b1, 12'o5555, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 12'o7777, 1'b1, 1'b1);
        n_checks++;
        if ({dv[1], di[1], lr[1]} !== {1'b1, 2'd2, 1'b0})
            $display("FAIL flush_cycle: {valid,idx,lready} got %b want 1100", {dv[1], di[1], lr[1]});
        else
            n_pass++;
        cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
        n_checks++;
        if ({dv[1], bz[1]} !== 2'b00) $display("FAIL flush_after: {valid,busy} got %b want 00", {dv[1], bz[1]});
        else n_pass++;
        cycle(1'b1, 1'b1, 12'o0123, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
            n_checks++;
            if ({dv[1], dd[1]} !== {1'b1, exp_d[k]})
                $display("FAIL flush_reload%0d: {valid,data} got %b want %b", k, {dv[1], dd[1]}, {1'b1, exp_d[k]});
            else
                n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        cycle(1'b1, 1'b1, 12'o6666, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 12'o0000, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
        n_checks++;
        if ({dv[1], lr[1]} !== 2'b01) $display("FAIL rst_mid_release: {valid,lready} got %b want 01", {dv[1], lr[1]});
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
            if (dv[1] || dv[0]) seen++;
        end
        n_checks++;
        if (seen != 0) $display("FAIL rst_mid_residual: got %0d valid cycles want 0", seen);
        else n_pass++;
    endtask

    task automatic test_random;
        for (int k = 0; k < 800; k++)
            cycle(1'b1, 1'($urandom_range(0, 1)), 12'($urandom),
                  ($urandom % 4) != 0, ($urandom % 16) == 0);
        for (int k = 0; k < 10; k++)
            cycle(1'b1, 1'b0, 12'o0000, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_msb_order();
        test_lsb_order();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
